regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file for the pipelined RV32I core, successor to the single-issue 2R/1W file.
- Adds configurable width, depth, read/write port count, write-to-read bypass, and a per-register busy scoreboard.
- Decode uses the scoreboard to detect RAW hazards on long-latency results such as loads.
- Sits between decode/issue (reads, busy set) and writeback (writes, busy clear).

---
 rtl/regfile_mp_sb.sv | 114 +++++++++++
 tb/tb_regfile_mp_sb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_sb
// Brief    : Multi-port integer register file with optional write-to-read
//            bypass and a per-register busy scoreboard for RAW detection.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic [NWR-1:0]       wr_clr,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic                 flush,
    output logic [NREGS-1:0]     busy_vec
);

    logic [NREGS*XLEN-1:0] r_mem;
    logic [NREGS*XLEN-1:0] w_mem_nxt;
    logic [NREGS-1:0]      r_busy;
    logic [NREGS-1:0]      w_busy_nxt;
    logic [NREGS-1:0]      w_clr;

    // Ports are walked in ascending order so the highest-index port wins.
    always_comb begin
        w_mem_nxt = r_mem;
        w_clr     = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                w_mem_nxt[int'(wr_addr[j*AW +: AW])*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                if (wr_clr[j]) begin
                    w_clr[wr_addr[j*AW +: AW]] = 1'b1;
                end
            end
        end
    end

    // Flush beats issue beats clear; x0 can never become busy.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < NREGS; r++) begin
            if (flush) begin
                w_busy_nxt[r] = 1'b0;
            end else if (iss_valid && (iss_rd == AW'(r)) && (r != 0)) begin
                w_busy_nxt[r] = 1'b1;
            end else if (w_clr[r]) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem  <= '0;
            r_busy <= '0;
        end else begin
            r_mem  <= w_mem_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_hit;
        logic            w_clr_hit;
        logic [XLEN-1:0] w_byp;

        assign w_ra = rd_addr[i*AW +: AW];

        always_comb begin
            w_hit     = 1'b0;
            w_clr_hit = 1'b0;
            w_byp     = '0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == w_ra)) begin
                    w_hit = 1'b1;
                    w_byp = wr_data[j*XLEN +: XLEN];
                    if (wr_clr[j]) begin
                        w_clr_hit = 1'b1;
                    end
                end
            end
        end

        // Reset gating keeps bypassed write data from leaking out while held.
        assign rd_data[i*XLEN +: XLEN] =
            (!rst_n || (w_ra == '0))    ? '0    :
            ((BYPASS != 0) && w_hit)    ? w_byp :
            r_mem[int'(w_ra)*XLEN +: XLEN];

        assign rd_busy[i] =
            (w_ra == '0)                ? 1'b0 :
            ((BYPASS != 0) && w_clr_hit) ? 1'b0 :
            r_busy[w_ra];
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp_sb
// Brief    : Bench for regfile_mp_sb; bypass and non-bypass instances share
//            stimulus and are compared against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]      rd_busy_b, rd_busy_n;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic [NREGS-1:0]    busy_vec_b, busy_vec_n;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush), .busy_vec(busy_vec_b)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush), .busy_vec(busy_vec_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input bit byp, input int a);
        logic [XLEN-1:0] v;
        v = m_regs[a];
        if (a == 0) return '0;
        if (byp) begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*XLEN +: XLEN];
        end
        return v;
    endfunction

    function automatic logic exp_busy(input bit byp, input int a);
        if (a == 0) return 1'b0;
        if (byp) begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_clr[j] && int'(wr_addr[j*AW +: AW]) == a) return 1'b0;
        end
        return m_busy[a];
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [31:0] v;
        for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic nb [NREGS];
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                m_regs[int'(wr_addr[j*AW +: AW])] = wr_data[j*XLEN +: XLEN];
        nb = m_busy;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_clr[j] && wr_addr[j*AW +: AW] != '0)
                nb[int'(wr_addr[j*AW +: AW])] = 1'b0;
        if (iss_valid && iss_rd != '0) nb[int'(iss_rd)] = 1'b1;
        if (flush)
            for (int r = 0; r < NREGS; r++) nb[r] = 1'b0;
        m_busy = nb;
    endtask

    task automatic check_outputs();
        int a;
        for (int i = 0; i < NRD; i++) begin
            a = int'(rd_addr[i*AW +: AW]);
            check("rd_data_byp", rd_data_b[i*XLEN +: XLEN], exp_rd(1'b1, a));
            check("rd_data_nobyp", rd_data_n[i*XLEN +: XLEN], exp_rd(1'b0, a));
            check("rd_busy_byp", 32'(rd_busy_b[i]), 32'(exp_busy(1'b1, a)));
            check("rd_busy_nobyp", 32'(rd_busy_n[i]), 32'(exp_busy(1'b0, a)));
        end
        check("busy_vec_byp", busy_vec_b, exp_vec());
        check("busy_vec_nobyp", busy_vec_n, exp_vec());
    endtask

    // Inputs are driven at negedge; outputs checked 1 unit later, model advanced at posedge.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; wr_clr = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0; rd_addr = '0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d, input bit clr);
        wr_en[j] = 1'b1;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*XLEN +: XLEN] = d;
        wr_clr[j] = clr;
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic issue(input int a);
        iss_valid = 1'b1;
        iss_rd = AW'(a);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy_vec", busy_vec_b, 32'h0);
        check("reset_rd_data", rd_data_b[0 +: XLEN], 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read, same cycle and next cycle.
        idle(); set_wr(0, 5, 32'hDEADBEEF, 1'b0); set_rd(1, 5);
        #1;
        check("same_cycle_byp", rd_data_b[XLEN +: XLEN], 32'hDEADBEEF);
        check("same_cycle_nobyp", rd_data_n[XLEN +: XLEN], 32'h0);
        tick();
        idle(); set_rd(1, 5);
        #1;
        check("next_cycle_byp", rd_data_b[XLEN +: XLEN], 32'hDEADBEEF);
        check("next_cycle_nobyp", rd_data_n[XLEN +: XLEN], 32'hDEADBEEF);
        tick();

        // x0 protection.
        idle(); set_wr(0, 0, 32'h12345678, 1'b1); issue(0); set_rd(0, 0);
        #1;
        check("x0_read_bypass", rd_data_b[0 +: XLEN], 32'h0);
        tick();
        idle(); set_rd(0, 0);
        #1;
        check("x0_read_stored", rd_data_b[0 +: XLEN], 32'h0);
        check("x0_busy", 32'(busy_vec_b[0]), 32'h0);
        tick();

        // Write port conflict: highest index wins.
        idle(); set_wr(0, 7, 32'h1, 1'b0); set_wr(1, 7, 32'h2, 1'b0); set_rd(0, 7);
        #1;
        check("conflict_bypass", rd_data_b[0 +: XLEN], 32'h2);
        tick();
        idle(); set_rd(0, 7);
        #1;
        check("conflict_stored_byp", rd_data_b[0 +: XLEN], 32'h2);
        check("conflict_stored_nobyp", rd_data_n[0 +: XLEN], 32'h2);
        tick();

        // Scoreboard set, clear, and issue-beats-clear.
        idle(); issue(9);
        tick();
        idle(); set_rd(0, 9);
        #1;
        check("sb_set", 32'(busy_vec_b[9]), 32'h1);
        set_wr(0, 9, 32'hA5A5A5A5, 1'b1);
        #1;
        check("sb_clr_rdbusy_byp", 32'(rd_busy_b[0]), 32'h0);
        check("sb_clr_rdbusy_nobyp", 32'(rd_busy_n[0]), 32'h1);
        tick();
        idle();
        #1;
        check("sb_cleared", 32'(busy_vec_b[9]), 32'h0);
        issue(9);
        tick();
        idle(); issue(9); set_wr(1, 9, 32'h5A5A5A5A, 1'b1);
        tick();
        idle();
        #1;
        check("sb_issue_beats_clear", 32'(busy_vec_b[9]), 32'h1);

        // Flush overrides a same-cycle issue and leaves data alone.
        issue(3); tick();
        idle(); issue(4); tick();
        idle(); issue(10); tick();
        idle();
        #1;
        check("pre_flush_vec", busy_vec_b, 32'h0000_0618);
        flush = 1'b1; issue(11);
        tick();
        idle(); set_rd(0, 5); set_rd(1, 7);
        #1;
        check("flush_vec", busy_vec_b, 32'h0);
        check("flush_keeps_r5", rd_data_b[0 +: XLEN], 32'hDEADBEEF);
        check("flush_keeps_r7", rd_data_b[XLEN +: XLEN], 32'h2);
        tick();

        // Randomized traffic with deliberate address collisions.
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int j = 0; j < NWR; j++) begin
                wr_en[j] = 1'($urandom_range(0, 1));
                wr_clr[j] = 1'($urandom_range(0, 1));
                wr_addr[j*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
                wr_data[j*XLEN +: XLEN] = $urandom;
            end
            for (int i = 0; i < NRD; i++)
                rd_addr[i*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
            flush = ($urandom_range(0, 15) == 0);
            tick();
        end

        // Asynchronous reset mid-cycle with writes and issue pending.
        idle(); issue(13); set_wr(0, 12, 32'hCAFEF00D, 1'b0);
        tick();
        idle(); issue(14); set_wr(0, 12, 32'h0BADF00D, 1'b0); set_wr(1, 5, 32'h11111111, 1'b0);
        set_rd(0, 12); set_rd(1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd0", rd_data_b[0 +: XLEN], 32'h0);
        check("async_rst_rd1", rd_data_b[XLEN +: XLEN], 32'h0);
        check("async_rst_vec", busy_vec_b, 32'h0);
        check("async_rst_rd_nobyp", rd_data_n[XLEN +: XLEN], 32'h0);
        idle();
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        set_rd(0, 12); set_rd(1, 5);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
